// File: rtl/game_pkg.sv
// Shared types and helpers for the whack-a-target game engine.
// Holds the state enum, LFSR tap mask and a one-hot helper.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_GAMEOVER
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] onehot(
    input logic [31:0] idx,
    input int unsigned n
  );
    logic [31:0] r;
    r = '0;
    if (idx < n) r = 32'd1 << idx;
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, advances one step per cycle while en is high.
// Ports: clk, rst (async high), en, q[15:0] current state.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-target game engine: random target LED, timed rounds, score.
// Ports: clk, rst, sw_pressed, start -> ledr, score, misses, point, game_over.
module whack_game_core
  import game_pkg::*;
#(
  parameter int unsigned N_SW         = 18,
  parameter int unsigned SCORE_W      = 11,
  parameter int unsigned ROUND_CYCLES = 50_000_000,
  parameter int unsigned MAX_MISSES   = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SW-1:0]    sw_pressed,
  input  logic               start,
  output logic [N_SW-1:0]    ledr,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               point,
  output logic               game_over
);

  localparam int unsigned IDX_W = $clog2(N_SW);
  localparam int unsigned TW_C  = $clog2(ROUND_CYCLES);
  localparam int unsigned TW    = (TW_C > 0) ? TW_C : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [3:0] MISS_LIM = 4'(MAX_MISSES);

  state_t            state;
  logic [N_SW-1:0]   sw_prev;
  logic [TW-1:0]     timer;
  logic [15:0]       lq;
  logic [IDX_W-1:0]  cand;
  logic              cand_ok;
  logic [N_SW-1:0]   cand_oh;
  logic [N_SW-1:0]   press;
  logic              hit;
  logic              wrong;
  logic [3:0]        miss_nx;
  logic              last_miss;
  logic [SCORE_W-1:0] score_nx;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (state == S_ARM),
    .q   (lq)
  );

  assign cand    = lq[IDX_W-1:0];
  assign cand_ok = {{(32-IDX_W){1'b0}}, cand} < N_SW;
  assign cand_oh = N_SW'(onehot({{(32-IDX_W){1'b0}}, cand}, N_SW));

  // In PLAY, ledr holds exactly the target one-hot.
  assign press = sw_pressed & ~sw_prev;
  assign hit   = |(press & ledr);
  assign wrong = |(press & ~ledr);

  assign miss_nx   = misses + 4'd1;
  assign last_miss = (miss_nx == MISS_LIM);
  assign score_nx  = (&score) ? score : score + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ledr      <= '0;
      score     <= '0;
      misses    <= '0;
      point     <= 1'b0;
      game_over <= 1'b0;
      timer     <= '0;
      sw_prev   <= '0;
    end else begin
      sw_prev <= sw_pressed;
      point   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ledr <= '0;
          if (start) begin
            state  <= S_ARM;
            score  <= '0;
            misses <= '0;
          end
        end
        S_ARM: begin
          if (cand_ok) begin
            ledr  <= cand_oh;
            timer <= T_LOAD;
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (wrong || (!hit && timer == '0)) begin
            misses <= miss_nx;
            if (last_miss) begin
              state     <= S_GAMEOVER;
              ledr      <= '1;
              game_over <= 1'b1;
            end else begin
              state <= S_ARM;
            end
          end else if (hit) begin
            score <= score_nx;
            point <= 1'b1;
            state <= S_ARM;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAMEOVER: begin
          ledr      <= '1;
          game_over <= 1'b1;
          if (start) begin
            state     <= S_ARM;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_game_core.sv
// Directed scoreboard bench for whack_game_core (N_SW=4, 8-cycle rounds).
// Expected status words are queued per step and popped after the edge.
module tb_whack_game_core;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_pressed = '0;
  logic       start = 1'b0;
  logic [3:0] ledr;
  logic [1:0] score;
  logic [3:0] misses;
  logic       point;
  logic       game_over;

  whack_game_core #(
    .N_SW(4),
    .SCORE_W(2),
    .ROUND_CYCLES(8),
    .MAX_MISSES(2),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_pressed(sw_pressed),
    .start(start),
    .ledr(ledr),
    .score(score),
    .misses(misses),
    .point(point),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [15:0] m = SEED;
  logic [1:0]  tgt = '0;
  logic [3:0]  e_led = '0;
  logic        e_go = 1'b0;
  logic        e_pt = 1'b0;
  logic [3:0]  e_miss = '0;
  logic [1:0]  e_score = '0;

  function automatic logic [11:0] obs();
    return {ledr, game_over, point, misses, score};
  endfunction

  function automatic logic [11:0] st();
    return {e_led, e_go, e_pt, e_miss, e_score};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.val = st();
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [11:0] o;
    e = sb.pop_front();
    o = obs();
    n_chk++;
    assert (o === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic step(input string tag);
    push(tag);
    tick();
    check_pop();
  endtask

  // ARM -> PLAY: target comes from the current LFSR, which then advances.
  task automatic arm();
    tgt   = m[1:0];
    e_led = 4'b0001 << tgt;
    m     = m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    step("arm");
  endtask

  task automatic hit(input string tag);
    sw_pressed = 4'b0001 << tgt;
    e_score = (e_score == 2'd3) ? 2'd3 : e_score + 2'd1;
    e_pt = 1'b1;
    step(tag);
    e_pt = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    push("reset");
    check_pop();
    rst = 1'b0;
    step("idle");

    start = 1'b1;
    step("start");
    start = 1'b0;
    arm();

    hit("hit1");
    arm();
    step("held");
    sw_pressed = '0;
    for (int i = 0; i < 6; i++) step("wait1");
    e_miss = 4'd1;
    step("tmo1");
    arm();

    for (int i = 0; i < 7; i++) step("wait2");
    e_miss = 4'd2;
    e_go   = 1'b1;
    e_led  = 4'hF;
    step("tmo2");
    step("over_hold");

    start = 1'b1;
    e_score = '0;
    e_miss  = '0;
    e_go    = 1'b0;
    step("restart");
    start = 1'b0;
    arm();

    sw_pressed = (4'b0001 << tgt) | (4'b0001 << (tgt + 2'd1));
    e_miss = 4'd1;
    step("dual");
    sw_pressed = '0;
    arm();

    for (int k = 0; k < 4; k++) begin
      hit($sformatf("hit_sat%0d", k));
      sw_pressed = '0;
      arm();
    end

    rst = 1'b1;
    e_led = '0; e_go = 1'b0; e_pt = 1'b0;
    e_miss = '0; e_score = '0;
    m = SEED;
    #1;
    push("mid_rst");
    check_pop();
    tick();
    rst = 1'b0;
    step("idle2");
    start = 1'b1;
    step("start2");
    start = 1'b0;
    arm();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/whack_game_core.md
# whack_game_core

Parametrised whack-a-target game engine that supersedes the fixed game_logic plus top-level score counter. It takes debounced switch levels, lights one pseudo-random target LED per round, scores rising-edge presses against a per-round timeout, tracks misses against a life limit, and owns a saturating score. It sits between the per-switch debounce array and the display driver.

## Interface
- N_SW, 18, number of switches/LEDs (2..32)
- SCORE_W, 11, score width
- ROUND_CYCLES, 50_000_000, clock cycles allowed per round
- MAX_MISSES, 3, misses that end the game (1..15)
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw_pressed  in  N_SW  debounced switch levels
- start  in  1  one-cycle pulse: begin or restart a game
- ledr  out  N_SW  registered LED pattern
- score  out  SCORE_W  current score, saturating
- misses  out  4  misses this game
- point  out  1  one-cycle pulse per hit
- game_over  out  1  high while in GAMEOVER

## Operation
- Press = rising edge: sw_pressed & ~sw_prev; sw_prev registered every cycle in all states.
- 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances only in ARM; candidate index = low IDX_W bits, IDX_W = $clog2(N_SW).
- States: IDLE, ARM, PLAY, GAMEOVER.
- IDLE: ledr=0. start -> ARM, score=0, misses=0.
- ARM: advance LFSR; if candidate < N_SW, latch target, load timer = ROUND_CYCLES-1, ledr = one-hot(target), -> PLAY; else stay in ARM.
- PLAY, per cycle, priority order:
  - Any press on a non-target switch -> miss, even if the target was also pressed that cycle.
  - Else target press -> hit: score+1 (held at all-ones), point=1, -> ARM.
  - Else timer==0 -> miss.
  - Else timer-1.
- Miss: misses+1; if new value == MAX_MISSES -> GAMEOVER, else -> ARM.
- GAMEOVER: ledr = all ones, game_over=1, score and misses held; start -> ARM with score=0, misses=0.
- start in ARM or PLAY is ignored.
- Presses outside PLAY are ignored. A switch held through ARM produces no press.

## Timing
- Reset values: state IDLE, ledr 0, score 0, misses 0, point 0, game_over 0, timer 0, sw_prev 0, LFSR = LFSR_SEED.
- A press edge in PLAY at cycle t gives score, misses, point and state updates at edge t+1. point is high for exactly that one cycle.
- ARM lasts >=1 cycle (longer while the candidate is out of range). ledr changes on the ARM -> PLAY edge.
- Round timeout: miss registered exactly ROUND_CYCLES cycles after entering PLAY.
- rst mid-game returns every register to its reset value immediately; no pending point is emitted.

## Structure
- game_pkg: state enum, LFSR tap constant, function onehot(idx, N).
- One sub-module: lfsr16 (clk, rst, en, seed param, q[15:0]).
- Timer width: $clog2(ROUND_CYCLES).

## Test plan
Use N_SW=4, ROUND_CYCLES=8, MAX_MISSES=2, SCORE_W=2 unless noted.
- Reset, then start -> ledr 0 until ARM completes, then exactly one bit set. score=0, misses=0.
- Press the lit switch -> point high for 1 cycle, score=1, new one-hot within a few cycles.
- No press for 8 cycles -> misses=1, new target. A second timeout -> game_over=1, ledr=4'b1111, score held.
- Target and a wrong switch rise in the same cycle -> counts as a miss, point stays 0, score unchanged.
- Four hits with SCORE_W=2 -> score 1,2,3,3; point pulses on all four.
- In GAMEOVER, start -> score=0, misses=0, ARM. Assert rst mid-PLAY -> all outputs 0 next cycle, state IDLE.
